// File: rtl/cac_link_pkg.sv
// Shared types and defaults for the CAC link arbiter.
// The coder payload width mirrors BLEN_07 (7-TSV Fibonacci CAC carries 5 bits).
package cac_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int DEFAULT_N_REQ     = 4;
    localparam int DEFAULT_DATA_W    = 5;
    localparam int DEFAULT_BURST_MAX = 2;
    localparam int DEFAULT_CNT_W     = 16;

    // Width of a requester index; never below 1 so the tag port always exists.
    function automatic int src_w(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/cac_link_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first set request at or after the
// pointer, wrapping past N-1, returned as one-hot and as an index.
module rr_pick
    import cac_link_pkg::*;
#(
    parameter int N  = DEFAULT_N_REQ,
    parameter int SW = src_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [SW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
                any_o                            = 1'b1;
                grant_o[(int'(ptr_i) + i) % N]   = 1'b1;
                idx_o                            = SW'((int'(ptr_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/cac_link_arbiter.sv
// Round-robin sequencer sharing one CACcoder_7 between N_REQ requesters;
// registers the granted word onto the coder and tags the coded TSV word with its source.
module cac_link_arbiter
    import cac_link_pkg::*;
#(
    parameter int N_REQ     = DEFAULT_N_REQ,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_MAX = DEFAULT_BURST_MAX,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      tx_ready,
    output logic [DATA_W-1:0]         coder_data,
    output logic                      coder_strobe,
    output logic                      link_valid,
    output logic [src_w(N_REQ)-1:0]   link_src,
    output logic                      busy,
    output logic [CNT_W-1:0]          word_count
);

    localparam int SRC_W = src_w(N_REQ);
    localparam int BC_W  = $clog2(BURST_MAX + 1);

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   owner_oh_q, owner_oh_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [BC_W-1:0]    burst_q, burst_d;

    logic [DATA_W-1:0]  coder_data_q;
    logic               coder_strobe_q;
    logic [SRC_W-1:0]   src1_q;
    logic [SRC_W-1:0]   link_src_q;
    logic               link_valid_q;
    logic [CNT_W-1:0]   word_count_q;

    logic [N_REQ-1:0]   pick_oh;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;

    logic               owner_valid;
    logic               others_valid;
    logic               xfer;
    logic [BC_W-1:0]    burst_inc;
    logic               at_max;
    logic [SRC_W-1:0]   ptr_after_owner;
    logic [DATA_W-1:0]  sel_word;

    rr_pick #(
        .N  (N_REQ),
        .SW (SRC_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign owner_valid     = |(req_valid & owner_oh_q);
    assign others_valid    = |(req_valid & ~owner_oh_q);
    assign xfer            = (state_q == SEND) && owner_valid && tx_ready;
    assign burst_inc       = burst_q + 1'b1;
    assign at_max          = (burst_inc == BC_W'(BURST_MAX));
    assign ptr_after_owner = (owner_q == SRC_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == SRC_W'(i)) begin
                sel_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            owner_oh_q <= N_REQ'(1);
            ptr_q      <= '0;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            ptr_q      <= ptr_d;
            burst_q    <= burst_d;
        end
    end

    // Next state: a grant is released when the owner goes quiet, or when the
    // burst is spent and somebody else is waiting; a lone requester keeps it.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        ptr_d      = ptr_q;
        burst_d    = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d    = pick_idx;
                    owner_oh_d = pick_oh;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!owner_valid) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after_owner;
                    burst_d = '0;
                end else if (xfer) begin
                    if (at_max && others_valid) begin
                        state_d = IDLE;
                        ptr_d   = ptr_after_owner;
                        burst_d = '0;
                    end else if (at_max) begin
                        burst_d = '0;
                    end else begin
                        burst_d = burst_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake: requester i hands over a word at a rising edge where
    // req_valid[i] & req_ready[i]; ready is offered only to the owner while
    // the link accepts, and a requester must hold valid and data until taken.
    always_comb begin
        busy      = (state_q != IDLE);
        req_ready = '0;
        if (state_q == SEND && tx_ready) begin
            req_ready = req_valid & owner_oh_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            coder_data_q   <= '0;
            coder_strobe_q <= 1'b0;
            src1_q         <= '0;
            link_src_q     <= '0;
            link_valid_q   <= 1'b0;
            word_count_q   <= '0;
        end else begin
            coder_strobe_q <= xfer;
            link_valid_q   <= coder_strobe_q;
            link_src_q     <= src1_q;
            if (xfer) begin
                coder_data_q <= sel_word;
                src1_q       <= owner_q;
                word_count_q <= word_count_q + 1'b1;
            end
        end
    end

    assign coder_data   = coder_data_q;
    assign coder_strobe = coder_strobe_q;
    assign link_valid   = link_valid_q;
    assign link_src     = link_src_q;
    assign word_count   = word_count_q;

endmodule
